// File: rtl/add_share_ctrl_pkg.sv
// Shared definitions for the add_share_ctrl block: default sizing constants,
// the controller state encoding and a width helper used for requester IDs
// and the latency counter.
package add_share_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_ADD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bits needed to index n items, never less than one so that
    // single-value fields still have a legal declaration.
    function automatic int clog2w(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/add_share_ctrl_if.sv
// Bus bundle for add_share_ctrl: requester handshake, shared-adder operand
// and result lines, and the response handshake.
//   master : the controller (drives req_ready, add_a/add_b, rsp_*)
//   slave  : the surroundings (requesters, adder, response consumer)
interface add_share_ctrl_if
    import add_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IDW = clog2w(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;

    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic [WIDTH-1:0]       add_sum;
    logic                   add_cout;

    logic                   rsp_valid;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_cout;
    logic                   rsp_ready;

    modport master (
        input  req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        output req_valid, req_a, req_b, add_sum, add_cout, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

endinterface

// File: rtl/add_share_ctrl_rr_arbiter.sv
// Combinational round-robin search: returns the first set bit of req starting
// at index ptr and wrapping modulo N_REQ.
//   req          : request vector
//   ptr          : highest-priority index this cycle
//   grant_onehot : one-hot winner (all zero when nothing requests)
//   grant_idx    : winner index (zero when nothing requests)
//   any          : at least one request present
module rr_arbiter
    import add_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDW   = clog2w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IDW-1:0]   grant_idx,
    output logic             any
);

    // Walk from ptr upward; the first hit wins and masks later candidates.
    always_comb begin
        int idx_s;
        idx_s        = 0;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = (int'(ptr) + k) % N_REQ;
            if (!any && req[IDW'(idx_s)]) begin
                grant_onehot[IDW'(idx_s)] = 1'b1;
                grant_idx                 = IDW'(idx_s);
                any                       = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/add_share_ctrl.sv
// Round-robin controller sharing one external adder among N_REQ requesters.
// One operation at a time: grant in IDLE, hold operands for ADD_LAT edges in
// WAIT, then present the captured result in RESP until it is taken.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : add_share_ctrl_if.master (request, adder and response lines)
module add_share_ctrl
    import add_share_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic          clk,
    input  logic          rst,
    add_share_ctrl_if.master bus
);

    localparam int IDW   = clog2w(N_REQ);
    localparam int CNT_W = clog2w(ADD_LAT + 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_RESP = ST_RESP;

    logic [1:0]       state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [IDW-1:0]   id_r;
    logic [CNT_W-1:0] cnt_r;

    logic [N_REQ-1:0] grant_onehot_s;
    logic [IDW-1:0]   grant_idx_s;
    logic             any_s;
    logic [IDW-1:0]   next_ptr_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req          (bus.req_valid),
        .ptr          (rr_ptr_r),
        .grant_onehot (grant_onehot_s),
        .grant_idx    (grant_idx_s),
        .any          (any_s)
    );

    // Winner's operands and the pointer value just past the winner.
    always_comb begin
        sel_a_s = bus.req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
        sel_b_s = bus.req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
        if (int'(grant_idx_s) == (N_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + 1'b1;
        end
    end

    // Grant is only offered in IDLE; reset is folded in so req_ready reads
    // zero for the whole time rst is held, even with requests pending.
    always_comb begin
        if ((state_r == S_IDLE) && !rst) begin
            bus.req_ready = grant_onehot_s;
        end else begin
            bus.req_ready = '0;
        end
    end

    // Controller state, operand registers and captured response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            rr_ptr_r      <= '0;
            id_r          <= '0;
            cnt_r         <= '0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    // any_s implies the granted requester's valid is high,
                    // so this is the accept edge.
                    if (any_s) begin
                        bus.add_a <= sel_a_s;
                        bus.add_b <= sel_b_s;
                        id_r      <= grant_idx_s;
                        rr_ptr_r  <= next_ptr_s;
                        cnt_r     <= CNT_W'(ADD_LAT);
                        state_r   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - 1'b1;
                    end else begin
                        bus.rsp_sum   <= bus.add_sum;
                        bus.rsp_cout  <= bus.add_cout;
                        bus.rsp_id    <= id_r;
                        bus.rsp_valid <= 1'b1;
                        state_r       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state_r       <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_share_ctrl.sv
// Self-checking bench for add_share_ctrl. Three controllers (ADD_LAT = 1, 0, 3)
// share the requester stimulus; sel chooses which one sees req_valid and whose
// outputs are observed. Each has its own behavioural adder of matching latency.
module tb_add_share_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_ready;
    int          sel;

    int n_chk;
    int n_fail;

    add_share_ctrl_if #(.N_REQ(4), .WIDTH(16)) if1 ();
    add_share_ctrl_if #(.N_REQ(4), .WIDTH(16)) if0 ();
    add_share_ctrl_if #(.N_REQ(4), .WIDTH(16)) if3 ();

    add_share_ctrl #(.N_REQ(4), .WIDTH(16), .ADD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    add_share_ctrl #(.N_REQ(4), .WIDTH(16), .ADD_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    add_share_ctrl #(.N_REQ(4), .WIDTH(16), .ADD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    // Requester side: shared operands, valid gated per controller.
    assign if1.req_valid = (sel == 0) ? req_valid : 4'b0000;
    assign if0.req_valid = (sel == 1) ? req_valid : 4'b0000;
    assign if3.req_valid = (sel == 2) ? req_valid : 4'b0000;
    assign if1.req_a = req_a;
    assign if0.req_a = req_a;
    assign if3.req_a = req_a;
    assign if1.req_b = req_b;
    assign if0.req_b = req_b;
    assign if3.req_b = req_b;
    assign if1.rsp_ready = rsp_ready;
    assign if0.rsp_ready = rsp_ready;
    assign if3.rsp_ready = rsp_ready;

    // Behavioural adders: combinational, one-stage and three-stage.
    logic [16:0] p1;
    logic [16:0] p3_1;
    logic [16:0] p3_2;
    logic [16:0] p3_3;
    assign {if0.add_cout, if0.add_sum} = {1'b0, if0.add_a} + {1'b0, if0.add_b};
    always_ff @(posedge clk) begin
        p1   <= {1'b0, if1.add_a} + {1'b0, if1.add_b};
        p3_1 <= {1'b0, if3.add_a} + {1'b0, if3.add_b};
        p3_2 <= p3_1;
        p3_3 <= p3_2;
    end
    assign {if1.add_cout, if1.add_sum} = p1;
    assign {if3.add_cout, if3.add_sum} = p3_3;

    // Observation mux over the selected controller.
    logic [3:0]  m_ready;
    logic        m_valid;
    logic [1:0]  m_id;
    logic [15:0] m_sum;
    logic        m_cout;
    logic [15:0] m_adda;
    logic [15:0] m_addb;
    always_comb begin
        case (sel)
            1: begin
                m_ready = if0.req_ready; m_valid = if0.rsp_valid; m_id = if0.rsp_id;
                m_sum = if0.rsp_sum; m_cout = if0.rsp_cout; m_adda = if0.add_a; m_addb = if0.add_b;
            end
            2: begin
                m_ready = if3.req_ready; m_valid = if3.rsp_valid; m_id = if3.rsp_id;
                m_sum = if3.rsp_sum; m_cout = if3.rsp_cout; m_adda = if3.add_a; m_addb = if3.add_b;
            end
            default: begin
                m_ready = if1.req_ready; m_valid = if1.rsp_valid; m_id = if1.rsp_id;
                m_sum = if1.rsp_sum; m_cout = if1.rsp_cout; m_adda = if1.add_a; m_addb = if1.add_b;
            end
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One request from requester id on the selected controller with
    // rsp_ready high. lat counts rising edges after the accept edge until
    // rsp_valid is seen; stable drops if add_a/add_b move during WAIT.
    task automatic txn(input int id, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] s, output logic c, output int rid,
                       output int lat, output bit stable);
        int k;
        @(negedge clk);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
        req_valid[id]      = 1'b1;
        rsp_ready          = 1'b1;
        #1;
        k = 0;
        while (!m_ready[id] && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("grant_timeout", 32'(k >= 50), 32'd0);
        @(negedge clk);
        req_valid[id] = 1'b0;
        stable = 1'b1;
        lat    = 0;
        while (!m_valid && lat < 50) begin
            if (m_adda !== a || m_addb !== b) begin
                stable = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        s   = m_sum;
        c   = m_cout;
        rid = int'(m_id);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!m_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(k >= 50), 32'd0);
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] ea[4];
    logic [15:0] eb[4];
    logic [15:0] es[4];
    logic        ec[4];
    logic [15:0] s;
    logic        c;
    int          rid;
    int          lat;
    bit          stable;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        sel       = 0;
        req_valid = 4'b0000;
        req_a     = 64'd0;
        req_b     = 64'd0;
        rsp_ready = 1'b1;

        vecs[0] = '{0, 16'h0001, 16'h0002, 16'h0003, 1'b0};
        vecs[1] = '{2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[2] = '{2, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
        vecs[3] = '{1, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        vecs[4] = '{3, 16'h1234, 16'h4321, 16'h5555, 1'b0};

        ea = '{16'hF0F0, 16'h1000, 16'hFFFF, 16'h0123};
        eb = '{16'h0F0F, 16'h2000, 16'hFFFF, 16'h0456};
        es = '{16'hFFFF, 16'h3000, 16'hFFFE, 16'h0579};
        ec = '{1'b0, 1'b0, 1'b1, 1'b0};

        // Reset values, including req_ready held low while requests pend.
        #3;
        chk("rst_rsp_valid", 32'(if1.rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(if1.rsp_id), 32'd0);
        chk("rst_rsp_sum", 32'(if1.rsp_sum), 32'd0);
        chk("rst_rsp_cout", 32'(if1.rsp_cout), 32'd0);
        chk("rst_add_a", 32'(if1.add_a), 32'd0);
        chk("rst_add_b", 32'(if1.add_b), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 32'(if1.req_ready), 32'd0);
        req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_no_req_ready", 32'(m_ready), 32'd0);

        // Table-driven single transactions, ADD_LAT = 1.
        for (int i = 0; i < 5; i++) begin
            txn(vecs[i].id, vecs[i].a, vecs[i].b, s, c, rid, lat, stable);
            chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
            chk($sformatf("vec%0d_id", i), 32'(rid), 32'(vecs[i].id));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_operands_stable", i), 32'(stable), 32'd1);
        end

        // Contention: all four valid from reset, expect 0,1,2,3,0.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = ea[i];
            req_b[i*16 +: 16] = eb[i];
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("cont_first_grant", 32'(m_ready), 32'h1);
        for (int r = 0; r < 5; r++) begin
            wait_valid($sformatf("cont%0d_timeout", r));
            chk($sformatf("cont%0d_id", r), 32'(m_id), 32'(r % 4));
            chk($sformatf("cont%0d_sum", r), 32'(m_sum), 32'(es[r % 4]));
            chk($sformatf("cont%0d_cout", r), 32'(m_cout), 32'(ec[r % 4]));
            @(negedge clk);
        end
        req_valid = 4'b0000;

        // Backpressure: requester 0 result held while requester 1 waits.
        @(negedge clk);
        req_a[15:0]  = 16'h0007;
        req_b[15:0]  = 16'h0009;
        req_a[31:16] = 16'h0100;
        req_b[31:16] = 16'h0200;
        rsp_ready    = 1'b0;
        req_valid    = 4'b0001;
        #1;
        chk("bp_grant0", 32'(m_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0010;
        wait_valid("bp_rsp_timeout");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_valid", i), 32'(m_valid), 32'd1);
            chk($sformatf("bp%0d_sum", i), 32'(m_sum), 32'h0010);
            chk($sformatf("bp%0d_id", i), 32'(m_id), 32'd0);
            chk($sformatf("bp%0d_req_ready", i), 32'(m_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_hs_valid", 32'(m_valid), 32'd0);
        chk("bp_after_hs_grant1", 32'(m_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        wait_valid("bp_req1_timeout");
        chk("bp_req1_id", 32'(m_id), 32'd1);
        chk("bp_req1_sum", 32'(m_sum), 32'h0300);

        // Reset during WAIT abandons the operation.
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        chk("mid_grant1", 32'(m_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b1111;
        rst       = 1'b1;
        #1;
        chk("mid_rst_add_a", 32'(m_adda), 32'd0);
        chk("mid_rst_add_b", 32'(m_addb), 32'd0);
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(m_ready), 32'd0);
        repeat (3) @(negedge clk);
        req_valid = 4'b0000;
        rst       = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_no_response", 32'(m_valid), 32'd0);
        req_valid = 4'b1001;
        #1;
        chk("mid_ptr_fresh", 32'(m_ready), 32'h1);
        req_valid = 4'b0000;
        txn(3, 16'h7000, 16'h9000, s, c, rid, lat, stable);
        chk("mid_req3_sum", 32'(s), 32'h0000);
        chk("mid_req3_cout", 32'(c), 32'd1);
        chk("mid_req3_id", 32'(rid), 32'd3);
        chk("mid_req3_latency", 32'(lat), 32'd2);

        // ADD_LAT sweep.
        @(negedge clk);
        sel = 1;
        txn(0, 16'h0001, 16'h0002, s, c, rid, lat, stable);
        chk("lat0_sum", 32'(s), 32'h0003);
        chk("lat0_id", 32'(rid), 32'd0);
        chk("lat0_latency", 32'(lat), 32'd1);
        chk("lat0_stable", 32'(stable), 32'd1);
        @(negedge clk);
        sel = 2;
        txn(0, 16'h0001, 16'h0002, s, c, rid, lat, stable);
        chk("lat3_sum", 32'(s), 32'h0003);
        chk("lat3_cout", 32'(c), 32'd0);
        chk("lat3_latency", 32'(lat), 32'd4);
        chk("lat3_stable", 32'(stable), 32'd1);
        txn(2, 16'hFFFF, 16'h0001, s, c, rid, lat, stable);
        chk("lat3_carry_sum", 32'(s), 32'h0000);
        chk("lat3_carry_cout", 32'(c), 32'd1);
        chk("lat3_carry_id", 32'(rid), 32'd2);
        chk("lat3_carry_latency", 32'(lat), 32'd4);
        chk("lat3_carry_stable", 32'(stable), 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
